// File: rtl/sample_tx_packer.sv
// Serializes 32-bit capture words into a byte stream for the host transmitter.
// Disabled channel groups are skipped with no bubble; busy covers the word plus an optional gap.
module sample_tx_packer #(
    parameter int GAP_CYCLES = 0,
    parameter bit LSB_FIRST  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send,
    input  logic [31:0] dataIn,
    input  logic [3:0]  disabledGroups,
    output logic        busy,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    input  logic        byte_ready,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t      state, state_d;
    logic [31:0] word, word_d;
    logic [3:0]  mask, mask_d;
    logic [7:0]  gap_cnt, gap_d;
    logic        overrun_d;
    logic [1:0]  cur_idx;
    logic [3:0]  mask_left;
    logic        accept;

    // Index of the next byte to present among the still-pending groups.
    function automatic logic [1:0] first_pending(input logic [3:0] m);
        first_pending = 2'd0;
        if (LSB_FIRST) begin
            for (int i = 3; i >= 0; i--)
                if (m[i]) first_pending = 2'(i);
        end else begin
            for (int i = 0; i < 4; i++)
                if (m[i]) first_pending = 2'(i);
        end
    endfunction

    assign cur_idx    = first_pending(mask);
    assign byte_valid = (state == SEND) && (mask != 4'b0000);
    assign byte_data  = word[{cur_idx, 3'b000} +: 8];
    assign busy       = (state != IDLE);
    assign accept     = byte_valid && byte_ready;
    assign mask_left  = mask & ~(4'b0001 << cur_idx);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            word    <= '0;
            mask    <= '0;
            gap_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_d;
            word    <= word_d;
            mask    <= mask_d;
            gap_cnt <= gap_d;
            overrun <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state;
        word_d    = word;
        mask_d    = mask;
        gap_d     = gap_cnt;
        overrun_d = overrun | (send & busy);
        case (state)
            IDLE: begin
                if (send) begin
                    word_d  = dataIn;
                    mask_d  = ~disabledGroups;
                    state_d = SEND;
                end
            end
            SEND: begin
                // An all-disabled word spends one busy cycle here with nothing to present.
                if (mask == 4'b0000 || (accept && mask_left == 4'b0000)) begin
                    mask_d = 4'b0000;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    mask_d = mask_left;
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) state_d = IDLE;
                else                 gap_d   = gap_cnt - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sample_tx_packer.sv
// Bench for sample_tx_packer: two instances (LSB-first/no gap, MSB-first/gap 3) against a queue model.
module tb_sample_tx_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        send = 1'b0;
    logic        byte_ready = 1'b0;
    logic [31:0] dataIn = '0;
    logic [3:0]  disabledGroups = '0;

    wire [1:0]       busy;
    wire [1:0]       byte_valid;
    wire [1:0]       overrun;
    wire [1:0][7:0]  byte_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int GAP = (g == 0) ? 0 : 3;
        localparam bit LSB = (g == 0);

        sample_tx_packer #(.GAP_CYCLES(GAP), .LSB_FIRST(LSB)) dut (
            .clock(clock), .reset(reset), .send(send), .dataIn(dataIn),
            .disabledGroups(disabledGroups), .busy(busy[g]), .byte_valid(byte_valid[g]),
            .byte_data(byte_data[g]), .byte_ready(byte_ready), .overrun(overrun[g])
        );

        // Model: queue of bytes still owed, plus a count of trailing busy-only cycles.
        logic [7:0] q[$];
        int         tail = 0;
        bit         ovr = 0;

        always @(posedge clock or posedge reset) begin
            if (reset) begin
                q.delete();
                tail = 0;
                ovr  = 0;
            end else begin
                bit bsy;
                bsy = (q.size() > 0) || (tail > 0);
                if (send && bsy) ovr = 1;
                if (send && !bsy) begin
                    for (int k = 0; k < 4; k++) begin
                        int idx;
                        idx = LSB ? k : 3 - k;
                        if (!disabledGroups[idx]) q.push_back(dataIn[8*idx +: 8]);
                    end
                    tail = (q.size() == 0) ? GAP + 1 : GAP;
                end else if (q.size() > 0) begin
                    if (byte_ready) void'(q.pop_front());
                end else if (tail > 0) begin
                    tail--;
                end
            end
        end

        always @(negedge clock) begin
            chk($sformatf("u%0d.busy", g), 32'(busy[g]), 32'((q.size() > 0) || (tail > 0)));
            chk($sformatf("u%0d.byte_valid", g), 32'(byte_valid[g]), 32'(q.size() > 0));
            if (q.size() > 0) chk($sformatf("u%0d.byte_data", g), 32'(byte_data[g]), 32'(q[0]));
            chk($sformatf("u%0d.overrun", g), 32'(overrun[g]), 32'(ovr));
        end
    end

    int          bcnt[2];
    int          nb[2];
    logic [31:0] gotw[2];
    int          d4;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy != 2'b00 && c < 200) begin
            tick();
            c++;
        end
        chk("wait_idle", 32'(c < 200), 32'd1);
    endtask

    // Send one word and follow it until both instances go idle; hold = accepts withheld on inst 0.
    task automatic run_word(input logic [31:0] d, input logic [3:0] dis, input int hold, input int ovr_at);
        int cyc = 0;
        int vcyc = 0;
        for (int g = 0; g < 2; g++) begin
            bcnt[g] = 0;
            nb[g]   = 0;
            gotw[g] = '0;
        end
        d4 = 0;
        send = 1'b1;
        dataIn = d;
        disabledGroups = dis;
        byte_ready = (hold == 0);
        tick();
        send = 1'b0;
        while (busy != 2'b00 && cyc < 100) begin
            send = (cyc == ovr_at);
            if (send) dataIn = ~d;
            byte_ready = (vcyc >= hold);
            if (byte_valid[0]) vcyc++;
            for (int g = 0; g < 2; g++) begin
                if (busy[g]) bcnt[g]++;
                if (byte_valid[g] && byte_ready) begin
                    gotw[g] = {gotw[g][23:0], byte_data[g]};
                    nb[g]++;
                end
            end
            if (byte_valid[0] && byte_data[0] == 8'hD4) d4++;
            cyc++;
            tick();
        end
        send = 1'b0;
        byte_ready = 1'b1;
        chk("word_done", 32'(cyc < 100), 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(byte_valid), 32'd0);
        chk("rst.data", 32'(byte_data), 32'd0);
        chk("rst.overrun", 32'(overrun), 32'd0);

        run_word(32'hA1B2C3D4, 4'b0000, 0, -1);
        chk("basic.bytes0", gotw[0], 32'hD4C3B2A1);
        chk("basic.nb0", 32'(nb[0]), 32'd4);
        chk("basic.busy0", 32'(bcnt[0]), 32'd4);
        chk("basic.bytes1", gotw[1], 32'hA1B2C3D4);
        chk("basic.busy1", 32'(bcnt[1]), 32'd7);
        chk("basic.overrun", 32'(overrun), 32'd0);

        run_word(32'h11223344, 4'b0101, 0, -1);
        chk("skip.bytes0", gotw[0], 32'h00003311);
        chk("skip.busy0", 32'(bcnt[0]), 32'd2);
        chk("skip.bytes1", gotw[1], 32'h00001133);
        chk("skip.busy1", 32'(bcnt[1]), 32'd5);

        run_word(32'hDEADBEEF, 4'b1111, 0, -1);
        chk("empty.nb0", 32'(nb[0]), 32'd0);
        chk("empty.nb1", 32'(nb[1]), 32'd0);
        chk("empty.busy0", 32'(bcnt[0]), 32'd1);
        chk("empty.busy1", 32'(bcnt[1]), 32'd4);

        run_word(32'hA1B2C3D4, 4'b0000, 5, -1);
        chk("bp.d4_cycles", 32'(d4), 32'd6);
        chk("bp.bytes0", gotw[0], 32'hD4C3B2A1);
        chk("bp.busy0", 32'(bcnt[0]), 32'd9);

        run_word(32'hA1B2C3D4, 4'b0000, 0, 2);
        chk("ovr.bytes0", gotw[0], 32'hD4C3B2A1);
        chk("ovr.flag", 32'(overrun[0]), 32'd1);
        repeat (3) tick();
        chk("ovr.sticky", 32'(overrun[0]), 32'd1);

        // Back-to-back: send on the first idle cycle of inst 0.
        send = 1'b1; dataIn = 32'hA1B2C3D4; disabledGroups = 4'b0000; byte_ready = 1'b1;
        tick();
        send = 1'b0;
        repeat (4) tick();
        chk("b2b.idle0", 32'(busy[0]), 32'd0);
        send = 1'b1; dataIn = 32'h00000077;
        tick();
        send = 1'b0;
        chk("b2b.valid0", 32'(byte_valid[0]), 32'd1);
        chk("b2b.data0", 32'(byte_data[0]), 32'h77);
        wait_idle();

        // Reset after the second accept.
        send = 1'b1; dataIn = 32'hA1B2C3D4; disabledGroups = 4'b0000; byte_ready = 1'b1;
        tick();
        send = 1'b0;
        tick();
        tick();
        chk("mid.data0", 32'(byte_data[0]), 32'hB2);
        #2 reset = 1'b1;
        #1;
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.valid", 32'(byte_valid), 32'd0);
        chk("mid.overrun", 32'(overrun), 32'd0);
        chk("mid.data", 32'(byte_data), 32'd0);
        tick();
        reset = 1'b0;
        send = 1'b1; dataIn = 32'h000000FF;
        tick();
        send = 1'b0;
        chk("post.valid0", 32'(byte_valid[0]), 32'd1);
        chk("post.data0", 32'(byte_data[0]), 32'hFF);
        wait_idle();

        repeat (3000) begin
            send = ($urandom_range(0, 3) == 0);
            dataIn = $urandom;
            disabledGroups = 4'($urandom_range(0, 15));
            byte_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        send = 1'b0;
        byte_ready = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_tx_packer.md
Name: sample_tx_packer

Overview:
- Downstream of the capture core: consumes each 32-bit word the core presents on memoryWrData/outputSend and serializes it into a byte stream for the host transmitter (UART/SPI).
- Drops bytes belonging to disabled channel groups.
- Drives the busy flag that the core samples as outputBusy.
- Single clock domain (core clock); byte-level valid/ready handshake toward the transmitter.

Parameters:
- GAP_CYCLES, 0, idle cycles inserted after the last byte of a word before busy deasserts (0..255).
- LSB_FIRST, 1, 1 = group 0 byte (bits 7:0) sent first; 0 = group 3 byte (bits 31:24) sent first.

Ports:
- clock  input  1  core clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- send  input  1  one-cycle request: transmit dataIn.
- dataIn  input  32  word to transmit; sampled only on accepted send.
- disabledGroups  input  4  bit n = 1 suppresses byte n; sampled with send.
- busy  output  1  word in progress; sends are ignored while high.
- byte_valid  output  1  byte_data holds a byte for the transmitter.
- byte_data  output  8  current byte.
- byte_ready  input  1  transmitter accepts the byte when byte_valid && byte_ready at a rising edge.
- overrun  output  1  sticky: a send arrived while busy; cleared only by reset.

Behaviour:
- Reset (async assert; synchronous-safe release): state=IDLE, busy=0, byte_valid=0, byte_data=8'h00, overrun=0, internal word/mask/counters=0.
- States: IDLE, SEND, GAP.
- IDLE:
  - send=1 latches dataIn into the shift word and ~disabledGroups into the pending mask.
  - If the mask is nonzero: next cycle SEND, busy=1, byte_valid=1, byte_data=first pending byte in LSB_FIRST order. Latency from send to byte_valid is 1 cycle.
  - If the mask is 4'b0000: no bytes are sent. busy=1 for exactly one cycle, then the block behaves as at end-of-word (GAP if GAP_CYCLES>0, else IDLE).
- SEND:
  - byte_data and byte_valid stay stable until accepted.
  - On accept, clear that byte's mask bit. If pending bits remain, the next pending byte is presented the following cycle with byte_valid still 1 (no bubble; disabled bytes are skipped with zero extra cycles).
  - On accept of the last pending byte: byte_valid=0 next cycle. If GAP_CYCLES=0, go to IDLE and busy=0 next cycle; otherwise go to GAP.
- GAP: busy=1, byte_valid=0. Count down GAP_CYCLES cycles, then go to IDLE with busy=0.
- send while busy=1: ignored; word and mask are unchanged; overrun=1 from the next cycle onward.
- send in the same cycle busy drops (the first IDLE cycle): accepted normally.
- byte_ready while byte_valid=0: ignored.
- byte_ready held permanently low: the block waits indefinitely with busy=1. There is no timeout.
- Reset mid-word: the in-flight byte and remaining bytes are discarded; outputs return to reset values immediately (async).
- Byte order, LSB_FIRST=1: group0 (7:0), group1, group2, group3. LSB_FIRST=0: reverse order.
- Max word length is 4 accepts. With byte_ready tied high, the word takes (enabled byte count)+GAP_CYCLES cycles of busy after the send cycle.

Test Plan:
- Basic word: LSB_FIRST=1, GAP=0, byte_ready=1, send with dataIn=32'hA1B2C3D4, disabledGroups=4'b0000 -> bytes D4,C3,B2,A1 on 4 consecutive cycles starting 1 cycle after send; busy high exactly 4 cycles; overrun=0.
- Group skip: disabledGroups=4'b0101, dataIn=32'h11223344 -> bytes 33 then 11 on consecutive cycles; busy high 2 cycles. Repeat with LSB_FIRST=0 -> 11 then 33.
- Back-pressure: byte_ready low for 5 cycles after byte_valid rises, then high -> byte_data stays D4 for 6 cycles, then C3,B2,A1 follow; no byte is lost or duplicated.
- All groups disabled: disabledGroups=4'b1111 -> byte_valid never asserts; busy high exactly 1 cycle (GAP=0), or 1+3 cycles with GAP_CYCLES=3.
- Overrun and back-to-back: second send 2 cycles into a 4-byte word -> ignored, overrun=1 and sticky. A send on the first cycle busy=0 is accepted and its first byte appears 1 cycle later.
- Reset mid-word: assert reset after the 2nd accept -> byte_valid=0 and busy=0 asynchronously. After release, a new send of 32'h000000FF yields FF first.
